// File: rtl/cache_req_master.sv
// CPU-side request initiator for the single-bus cache controller: queues host commands, issues one at a time, returns completions.
// Optional busy watchdog enabled by defining REQ_TIMEOUT_EN.
module cache_req_master #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACCEPT_WIN  = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_read,
  output logic [7:0] resp_addr,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic       start,
  output logic [7:0] address,
  output logic [7:0] write_data,
  output logic       read_operation,
  input  logic       cache_busy,
  input  logic [7:0] read_data,
  output logic       idle
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WIN_W = $clog2(ACCEPT_WIN + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ACCEPT_WIN == 0 || TIMEOUT_CYC == 0)
  begin : g_param_check
    $error("cache_req_master: illegal parameter value");
  end

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  cmd_t             mem [FIFO_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_d;
  logic [WIN_W-1:0] win_cnt, win_cnt_d;
  state_t           state, state_d;
  logic             push, pop, done, timed_out;
  logic             cmd_ready_d, idle_d, start_d, read_operation_d;
  logic [7:0]       address_d, write_data_d;
  logic             resp_valid_d, resp_read_d;
  logic [7:0]       resp_addr_d, resp_rdata_d;

`ifdef REQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             resp_err_d;
`endif

  assign head = mem[rd_ptr];

  // Command storage; entries need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: cmd_read, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_comb begin
    state_d          = state;
    win_cnt_d        = win_cnt;
    pop              = 1'b0;
    done             = 1'b0;
    timed_out        = 1'b0;
    address_d        = address;
    write_data_d     = write_data;
    read_operation_d = read_operation;
    resp_valid_d     = resp_valid;
    resp_read_d      = resp_read;
    resp_addr_d      = resp_addr;
    resp_rdata_d     = resp_rdata;
`ifdef REQ_TIMEOUT_EN
    tmo_cnt_d        = tmo_cnt;
    resp_err_d       = resp_err;
`endif
    push = cmd_valid && cmd_ready;

    case (state)
      // A still-busy cache (e.g. after a watchdog abort) holds off the next issue.
      S_IDLE: begin
        if (count != '0 && !resp_valid && !cache_busy) begin
          pop              = 1'b1;
          address_d        = head.addr;
          write_data_d     = head.wdata;
          read_operation_d = head.rd;
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        win_cnt_d = '0;
        state_d   = S_WAIT_ACCEPT;
      end
      // No busy within the window means the cache finished the access immediately.
      S_WAIT_ACCEPT: begin
        if (cache_busy) begin
          state_d = S_WAIT_DONE;
        end else if (win_cnt == WIN_W'(ACCEPT_WIN - 1)) begin
          done = 1'b1;
        end else begin
          win_cnt_d = win_cnt + WIN_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!cache_busy) begin
          done = 1'b1;
        end
`ifdef REQ_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      resp_valid_d = 1'b1;
      resp_read_d  = read_operation;
      resp_addr_d  = address;
      resp_rdata_d = (read_operation && !timed_out) ? read_data : 8'h00;
      state_d      = S_RESP;
`ifdef REQ_TIMEOUT_EN
      resp_err_d   = timed_out;
      tmo_cnt_d    = '0;
`endif
    end

    count_d     = count + CNT_W'(push) - CNT_W'(pop);
    start_d     = (state_d == S_ISSUE);
    cmd_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    idle_d      = (count_d == '0) && (state_d == S_IDLE) && !resp_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      win_cnt        <= '0;
      cmd_ready      <= 1'b1;
      idle           <= 1'b1;
      start          <= 1'b0;
      address        <= 8'h00;
      write_data     <= 8'h00;
      read_operation <= 1'b0;
      resp_valid     <= 1'b0;
      resp_read      <= 1'b0;
      resp_addr      <= 8'h00;
      resp_rdata     <= 8'h00;
    end else begin
      state          <= state_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count          <= count_d;
      win_cnt        <= win_cnt_d;
      cmd_ready      <= cmd_ready_d;
      idle           <= idle_d;
      start          <= start_d;
      address        <= address_d;
      write_data     <= write_data_d;
      read_operation <= read_operation_d;
      resp_valid     <= resp_valid_d;
      resp_read      <= resp_read_d;
      resp_addr      <= resp_addr_d;
      resp_rdata     <= resp_rdata_d;
    end
  end

`ifdef REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt  <= '0;
      resp_err <= 1'b0;
    end else begin
      tmo_cnt  <= tmo_cnt_d;
      resp_err <= resp_err_d;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_req_master.sv
// Self-checking bench for cache_req_master: behavioural cache model, response scoreboard, vector table plus corner sequences.
module tb_cache_req_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_read;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       resp_valid, resp_ready, resp_read, resp_err;
  logic [7:0] resp_addr, resp_rdata;
  logic       start, read_operation, cache_busy, idle;
  logic [7:0] address, write_data, read_data;

  always #5 clk = ~clk;

  cache_req_master #(.FIFO_DEPTH(4), .ACCEPT_WIN(2), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_read(resp_read),
    .resp_addr(resp_addr), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .start(start), .address(address), .write_data(write_data),
    .read_operation(read_operation), .cache_busy(cache_busy),
    .read_data(read_data), .idle(idle)
  );

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] rdata;
    logic       err;
  } resp_t;

  typedef struct {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         blen;
    int         lat;
    logic [7:0] exp_rdata;
  } vec_t;

  resp_t sb[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cache model: busy for busy_len cycles after start (0 = hit, never busy); read_data valid only once done.
  logic [7:0] cmem [256];
  int   busy_len = 1;
  int   cur_len  = 0;
  int   k        = 1000;
  logic data_ok  = 1'b1;
  initial begin
    foreach (cmem[i]) cmem[i] = 8'h00;
    cache_busy = 1'b0;
    read_data  = 8'hEE;
    forever begin
      @(posedge clk); #1;
      if (start) begin
        k = 0; cur_len = busy_len; data_ok = 1'b0; cache_busy = 1'b0;
        if (!read_operation) cmem[address] = write_data;
      end else if (k < 100000) begin
        k++;
        if (cur_len > 0) begin
          cache_busy = (k >= 1 && k <= cur_len);
          data_ok    = (k > cur_len);
        end else begin
          data_ok = (k >= 2);
        end
      end
      read_data = data_ok ? cmem[address] : 8'hEE;
    end
  end

  // start pulse monitor
  int   start_count = 0;
  int   start_width = 0;
  int   overlap     = 0;
  always @(negedge clk) begin
    if (start && cache_busy) overlap++;
    if (start) begin
      if (start_width == 0) start_count++;
      start_width++;
    end else if (start_width != 0) begin
      check("start_width", start_width, 1);
      start_width = 0;
    end
  end

  // response monitor / scoreboard
  int    hs_count = 0;
  logic  hold = 1'b0;
  resp_t held, mon_cur, mon_exp;
  always @(negedge clk) begin
    mon_cur = '{rd: resp_read, addr: resp_addr, rdata: resp_rdata, err: resp_err};
    if (hold && rst) begin
      check("resp_hold_valid", resp_valid, 1);
      check("resp_hold_payload", mon_cur, held);
    end
    hold = rst && resp_valid && !resp_ready;
    held = mon_cur;
    if (rst && resp_valid && resp_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        mon_exp = sb.pop_front();
        check("resp_payload", mon_cur, mon_exp);
      end
    end
  end

  logic [7:0] ref_mem [256];

  task automatic push_cmd(input logic rd, input logic [7:0] addr, input logic [7:0] wdata,
                          input bit expect_resp, input logic [7:0] exp_rdata, input logic exp_err);
    resp_t e;
    int    w;
    if (expect_resp) begin
      e = '{rd: rd, addr: addr, rdata: exp_rdata, err: exp_err};
      sb.push_back(e);
    end
    if (!rd) ref_mem[addr] = wdata;
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wdata;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin w++; @(negedge clk); end
    check("cmd_accepted", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 300);
  endtask

  task automatic wait_drain(input int budget);
    int w;
    w = 0;
    while ((sb.size() != 0 || !idle) && w < budget) begin @(negedge clk); w++; end
  endtask

  vec_t vecs [9];
  int   lat, s0, h0, w;

  initial begin
    vecs[0] = '{1'b0, 8'h3C, 8'hA5, 4, 8, 8'h00};
    vecs[1] = '{1'b1, 8'h3C, 8'h00, 4, 8, 8'hA5};
    vecs[2] = '{1'b0, 8'h10, 8'h5A, 0, 5, 8'h00};
    vecs[3] = '{1'b1, 8'h10, 8'h00, 0, 5, 8'h5A};
    vecs[4] = '{1'b0, 8'hFF, 8'h81, 1, 5, 8'h00};
    vecs[5] = '{1'b1, 8'hFF, 8'h00, 2, 6, 8'h81};
    vecs[6] = '{1'b1, 8'h3C, 8'h00, 1, 5, 8'hA5};
    vecs[7] = '{1'b0, 8'h00, 8'hC3, 3, 7, 8'h00};
    vecs[8] = '{1'b1, 8'h00, 8'h00, 0, 5, 8'hC3};
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;

    rst = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {start, read_operation, resp_valid, resp_err, resp_read}, 0);
    check("rst_data", {address, write_data, resp_addr, resp_rdata}, 0);
    check("rst_ready_idle", {cmd_ready, idle}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready_idle", {cmd_ready, idle}, 2'b11);
    check("post_rst_no_start", start_count, 0);
    @(posedge clk); #1;

    // one command at a time: payload via scoreboard, latency and start count here
    for (int i = 0; i < 9; i++) begin
      busy_len = vecs[i].blen;
      s0 = start_count;
      push_cmd(vecs[i].rd, vecs[i].addr, vecs[i].wdata, 1'b1, vecs[i].exp_rdata, 1'b0);
      wait_resp(lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("vec%0d_idle", i), idle, 1);
      check($sformatf("vec%0d_starts", i), start_count - s0, 1);
      @(posedge clk); #1;
    end

    // backpressure: one command in flight, four queued, then FIFO full
    busy_len = 1; resp_ready = 1'b0; h0 = hs_count;
    push_cmd(1'b0, 8'h20, 8'h11, 1'b1, 8'h00, 1'b0);
    push_cmd(1'b1, 8'h20, 8'h00, 1'b1, 8'h11, 1'b0);
    push_cmd(1'b0, 8'h21, 8'h22, 1'b1, 8'h00, 1'b0);
    push_cmd(1'b1, 8'h21, 8'h00, 1'b1, 8'h22, 1'b0);
    push_cmd(1'b1, 8'h3C, 8'h00, 1'b1, 8'hA5, 1'b0);
    @(negedge clk);
    check("bp_full_ready", cmd_ready, 0);
    repeat (4) @(negedge clk);
    check("bp_still_full", {cmd_ready, resp_valid}, 2'b01);
    check("bp_no_handshake", hs_count - h0, 0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    push_cmd(1'b0, 8'h20, 8'h33, 1'b1, 8'h00, 1'b0);
    wait_drain(400);
    check("bp_drain", sb.size(), 0);
    check("bp_hs_count", hs_count - h0, 6);
    @(posedge clk); #1;

    // reset while waiting on a long busy with two commands queued
    busy_len = 30; h0 = hs_count;
    push_cmd(1'b1, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0);
    push_cmd(1'b1, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0);
    push_cmd(1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);
    w = 0;
    while (!cache_busy && w < 50) begin @(negedge clk); w++; end
    check("rm_busy_seen", cache_busy, 1);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rm_in_reset", {resp_valid, idle, cmd_ready}, 3'b011);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rm_after", {resp_valid, idle, cmd_ready}, 3'b011);
    check("rm_no_resp", hs_count - h0, 0);
    check("rm_busy_held", cache_busy, 1);
    @(posedge clk); #1;

    // cache still busy while idle: the next command must wait for busy to drop
    busy_len = 1; s0 = start_count;
    push_cmd(1'b1, 8'h3C, 8'h00, 1'b1, 8'hA5, 1'b0);
    w = 0;
    while (cache_busy && w < 100) begin @(negedge clk); w++; end
    check("busy_idle_no_start", start_count - s0, 0);
    wait_drain(100);
    check("busy_idle_drain", sb.size(), 0);
    check("busy_idle_starts", start_count - s0, 1);
    @(posedge clk); #1;

`ifdef REQ_TIMEOUT_EN
    busy_len = 60;
    push_cmd(1'b1, 8'h10, 8'h00, 1'b1, 8'h00, 1'b1);
    wait_resp(lat);
    check("tmo_latency", lat, 12);
    check("tmo_err", resp_err, 1);
    @(posedge clk); #1;
    busy_len = 1; s0 = start_count;
    push_cmd(1'b1, 8'h10, 8'h00, 1'b1, 8'h5A, 1'b0);
    w = 0;
    while (cache_busy && w < 100) begin @(negedge clk); w++; end
    check("tmo_no_start_busy", start_count - s0, 0);
    wait_drain(100);
    check("tmo_drain", sb.size(), 0);
    @(posedge clk); #1;
`endif

    repeat (3) @(negedge clk);
    check("start_busy_overlap", overlap, 0);
    check("end_sb_empty", sb.size(), 0);
    check("end_idle", idle, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
